axi_master_interface: RTL and testbench

//  Initiator-side bridge: accepts requests on the simple user bus (addr/len

---
 rtl/axi_master_interface_if.sv | 96 +++++++++
 rtl/axi_master_interface.sv | 117 +++++++++++
 tb/tb_axi_master_interface.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_interface_if.sv
// Signal bundles for axi_master_interface: the simple user request bus and
// the AXI4 master port. In each bundle the master modport is the initiator side.
interface user_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  logic                    wr_err;
  logic                    rd_err;

  modport master (
    output awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    output araddr, arlen, arvalid, input arready,
    input  rdata, rlast, rvalid, output rready,
    input  wr_err, rd_err
  );
  modport slave (
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    input  araddr, arlen, arvalid, output arready,
    output rdata, rlast, rvalid, input rready,
    output wr_err, rd_err
  );
endinterface

interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_master_interface.sv
// User-bus to AXI4 master bridge: registered AW/AR slices, outstanding-burst
// caps, W beats gated behind accepted addresses, sticky response error flags.
module axi_master_interface #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_THREAD_ID  = 0,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic      ACLK,
  input  logic      ARESET,
  user_bus_if.slave usr,
  axi4_if.master    m_axi
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [2:0]    AXSIZE   = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_ZERO = {C_M_AXI_ADDR_WIDTH{1'b0}};

  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wcredit;
  logic aw_accept, ar_accept, w_last_beat, b_done, r_beat, r_last_beat;
  logic unused_ids;

  // Up/down counter step; simultaneous inc and dec cancel, never wraps below zero.
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] cnt,
                                             input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   cnt_step = cnt + CW'(1);
      2'b01:   cnt_step = (cnt != CNT_ZERO) ? cnt - CW'(1) : cnt;
      default: cnt_step = cnt;
    endcase
  endfunction

  assign usr.awready = (!m_axi.awvalid || m_axi.awready) && (wr_cnt < CNT_MAX);
  assign usr.arready = (!m_axi.arvalid || m_axi.arready) && (rd_cnt < CNT_MAX);
  assign aw_accept   = usr.awvalid && usr.awready;
  assign ar_accept   = usr.arvalid && usr.arready;
  assign b_done      = m_axi.bvalid;
  assign r_beat      = m_axi.rvalid && m_axi.rready;
  assign r_last_beat = r_beat && m_axi.rlast;
  assign w_last_beat = usr.wvalid && usr.wready && usr.wlast;

  // Fixed burst attributes; responses carry one thread so IDs are not inspected.
  assign m_axi.awid    = C_M_AXI_ID_WIDTH'(C_M_AXI_THREAD_ID);
  assign m_axi.awsize  = AXSIZE;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arid    = C_M_AXI_ID_WIDTH'(C_M_AXI_THREAD_ID);
  assign m_axi.arsize  = AXSIZE;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.bready  = 1'b1;
  assign unused_ids    = &{1'b0, m_axi.bid, m_axi.rid};

  assign m_axi.wvalid = usr.wvalid && (wcredit != CNT_ZERO);
  assign usr.wready   = m_axi.wready && (wcredit != CNT_ZERO);
  assign m_axi.wdata  = usr.wdata;
  assign m_axi.wstrb  = usr.wstrb;
  assign m_axi.wlast  = usr.wlast;

  assign usr.rdata    = m_axi.rdata;
  assign usr.rlast    = m_axi.rlast;
  assign usr.rvalid   = m_axi.rvalid;
  assign m_axi.rready = usr.rready;

  // AW slice: load on user accept, hold payload until the interconnect takes it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_axi.awvalid <= 1'b0;
      m_axi.awaddr  <= ADDR_ZERO;
      m_axi.awlen   <= 8'd0;
    end else if (aw_accept) begin
      m_axi.awvalid <= 1'b1;
      m_axi.awaddr  <= usr.awaddr;
      m_axi.awlen   <= usr.awlen;
    end else if (m_axi.awready) begin
      m_axi.awvalid <= 1'b0;
    end
  end

  // AR slice, same structure as AW.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_axi.arvalid <= 1'b0;
      m_axi.araddr  <= ADDR_ZERO;
      m_axi.arlen   <= 8'd0;
    end else if (ar_accept) begin
      m_axi.arvalid <= 1'b1;
      m_axi.araddr  <= usr.araddr;
      m_axi.arlen   <= usr.arlen;
    end else if (m_axi.arready) begin
      m_axi.arvalid <= 1'b0;
    end
  end

  // Outstanding-burst, write-credit counters and sticky error flags.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_cnt     <= CNT_ZERO;
      rd_cnt     <= CNT_ZERO;
      wcredit    <= CNT_ZERO;
      usr.wr_err <= 1'b0;
      usr.rd_err <= 1'b0;
    end else begin
      wr_cnt     <= cnt_step(wr_cnt, aw_accept, b_done);
      rd_cnt     <= cnt_step(rd_cnt, ar_accept, r_last_beat);
      wcredit    <= cnt_step(wcredit, aw_accept, w_last_beat);
      usr.wr_err <= usr.wr_err || (b_done && (m_axi.bresp != 2'b00));
      usr.rd_err <= usr.rd_err || (r_beat && (m_axi.rresp != 2'b00));
    end
  end
endmodule

// File: tb/tb_axi_master_interface.sv
// Directed bench for axi_master_interface: reset, single write, outstanding cap,
// W gating, AW stall, read with error response, asynchronous reset mid-burst.
module tb_axi_master_interface;
  logic ACLK;
  logic ARESET;
  int   vectors = 0;
  int   errors  = 0;

  user_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) usr ();
  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) axi ();

  axi_master_interface #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ID_WIDTH(1),
    .C_M_AXI_THREAD_ID(0), .MAX_OUTSTANDING(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .usr(usr), .m_axi(axi)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic drive_idle();
    usr.awaddr = 32'h0; usr.awlen = 8'd0; usr.awvalid = 1'b0;
    usr.wdata = 32'h0; usr.wstrb = 4'h0; usr.wlast = 1'b0; usr.wvalid = 1'b0;
    usr.araddr = 32'h0; usr.arlen = 8'd0; usr.arvalid = 1'b0; usr.rready = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bid = 1'b0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
    axi.arready = 1'b0; axi.rid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    axi.rlast = 1'b0; axi.rvalid = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    drive_idle();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    drive_idle();
    @(negedge ACLK);
    vectors++; if (axi.awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid: got %0h want 0", axi.awvalid); end
    vectors++; if (axi.arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %0h want 0", axi.arvalid); end
    vectors++; if (axi.awaddr !== 32'h0 || axi.awlen !== 8'd0) begin errors++; $display("FAIL rst_awpayload: got %0h/%0h want 0/0", axi.awaddr, axi.awlen); end
    vectors++; if (axi.araddr !== 32'h0 || axi.arlen !== 8'd0) begin errors++; $display("FAIL rst_arpayload: got %0h/%0h want 0/0", axi.araddr, axi.arlen); end
    vectors++; if (dut.wr_cnt !== 3'd0 || dut.rd_cnt !== 3'd0 || dut.wcredit !== 3'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d/%0d want 0/0/0", dut.wr_cnt, dut.rd_cnt, dut.wcredit); end
    vectors++; if (usr.wr_err !== 1'b0 || usr.rd_err !== 1'b0) begin errors++; $display("FAIL rst_errs: got %0b/%0b want 0/0", usr.wr_err, usr.rd_err); end
    vectors++; if (axi.awsize !== 3'd2 || axi.awburst !== 2'b01 || axi.awcache !== 4'b0011 || axi.awprot !== 3'b000 || axi.awid !== 1'b0) begin errors++; $display("FAIL aw_consts: got size=%0d burst=%0b cache=%0b prot=%0b id=%0b want 2/01/0011/000/0", axi.awsize, axi.awburst, axi.awcache, axi.awprot, axi.awid); end
    vectors++; if (axi.arsize !== 3'd2 || axi.arburst !== 2'b01 || axi.arcache !== 4'b0011 || axi.arprot !== 3'b000 || axi.arid !== 1'b0) begin errors++; $display("FAIL ar_consts: got size=%0d burst=%0b cache=%0b prot=%0b id=%0b want 2/01/0011/000/0", axi.arsize, axi.arburst, axi.arcache, axi.arprot, axi.arid); end
    vectors++; if (axi.bready !== 1'b1) begin errors++; $display("FAIL bready: got %0b want 1", axi.bready); end
    ARESET = 1'b0;
    #1;
    vectors++; if (usr.awready !== 1'b1 || usr.arready !== 1'b1) begin errors++; $display("FAIL idle_ready: got aw=%0b ar=%0b want 1/1", usr.awready, usr.arready); end
  endtask

  task automatic test_single_write();
    do_reset();
    usr.awaddr = 32'h100; usr.awlen = 8'd3; usr.awvalid = 1'b1;
    #1;
    vectors++; if (usr.awready !== 1'b1) begin errors++; $display("FAIL sw_awready: got %0b want 1", usr.awready); end
    vectors++; if (axi.awvalid !== 1'b0) begin errors++; $display("FAIL sw_aw_latency: got %0b want 0", axi.awvalid); end
    @(negedge ACLK);
    usr.awvalid = 1'b0;
    #1;
    vectors++; if (axi.awvalid !== 1'b1 || axi.awaddr !== 32'h100 || axi.awlen !== 8'd3) begin errors++; $display("FAIL sw_aw: got v=%0b a=%0h l=%0d want 1/100/3", axi.awvalid, axi.awaddr, axi.awlen); end
    vectors++; if (dut.wr_cnt !== 3'd1) begin errors++; $display("FAIL sw_wr_cnt_up: got %0d want 1", dut.wr_cnt); end
    axi.awready = 1'b1;
    @(negedge ACLK);
    axi.awready = 1'b0;
    #1;
    vectors++; if (axi.awvalid !== 1'b0) begin errors++; $display("FAIL sw_aw_drop: got %0b want 0", axi.awvalid); end
    axi.wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      usr.wvalid = 1'b1; usr.wdata = 32'hA0 + 32'(i); usr.wstrb = 4'hF; usr.wlast = (i == 3);
      #1;
      vectors++; if (axi.wvalid !== 1'b1 || usr.wready !== 1'b1 || axi.wdata !== 32'hA0 + 32'(i) || axi.wlast !== (i == 3) || axi.wstrb !== 4'hF) begin errors++; $display("FAIL sw_wbeat%0d: got v=%0b r=%0b d=%0h l=%0b want 1/1/%0h/%0b", i, axi.wvalid, usr.wready, axi.wdata, axi.wlast, 32'hA0 + 32'(i), (i == 3)); end
      @(negedge ACLK);
    end
    usr.wvalid = 1'b0; usr.wlast = 1'b0;
    #1;
    vectors++; if (dut.wcredit !== 3'd0 || usr.wready !== 1'b0) begin errors++; $display("FAIL sw_credit_done: got %0d/%0b want 0/0", dut.wcredit, usr.wready); end
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    @(negedge ACLK);
    axi.bvalid = 1'b0; axi.wready = 1'b0;
    #1;
    vectors++; if (dut.wr_cnt !== 3'd0 || usr.wr_err !== 1'b0) begin errors++; $display("FAIL sw_bresp: got cnt=%0d err=%0b want 0/0", dut.wr_cnt, usr.wr_err); end
  endtask

  task automatic test_outstanding_cap();
    do_reset();
    axi.awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      usr.awvalid = 1'b1; usr.awaddr = 32'h200 + 32'(i) * 32'h10; usr.awlen = 8'd0;
      #1;
      vectors++; if (usr.awready !== 1'b1) begin errors++; $display("FAIL cap_accept%0d: got %0b want 1", i, usr.awready); end
      @(negedge ACLK);
    end
    usr.awaddr = 32'h240;
    #1;
    vectors++; if (usr.awready !== 1'b0 || dut.wr_cnt !== 3'd4) begin errors++; $display("FAIL cap_full: got rdy=%0b cnt=%0d want 0/4", usr.awready, dut.wr_cnt); end
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    #1;
    vectors++; if (usr.awready !== 1'b0) begin errors++; $display("FAIL cap_same_cycle: got %0b want 0", usr.awready); end
    @(negedge ACLK);
    axi.bvalid = 1'b0;
    #1;
    vectors++; if (usr.awready !== 1'b1 || dut.wr_cnt !== 3'd3) begin errors++; $display("FAIL cap_reopen: got rdy=%0b cnt=%0d want 1/3", usr.awready, dut.wr_cnt); end
    @(negedge ACLK);
    usr.awvalid = 1'b0;
    #1;
    vectors++; if (dut.wr_cnt !== 3'd4 || axi.awaddr !== 32'h240 || axi.awvalid !== 1'b1) begin errors++; $display("FAIL cap_fifth: got cnt=%0d a=%0h v=%0b want 4/240/1", dut.wr_cnt, axi.awaddr, axi.awvalid); end
  endtask

  task automatic test_w_gating();
    do_reset();
    axi.awready = 1'b1; axi.wready = 1'b1;
    usr.wvalid = 1'b1; usr.wdata = 32'h11; usr.wstrb = 4'h3; usr.wlast = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (usr.wready !== 1'b0 || axi.wvalid !== 1'b0) begin errors++; $display("FAIL wg_blocked%0d: got rdy=%0b v=%0b want 0/0", i, usr.wready, axi.wvalid); end
      @(negedge ACLK);
    end
    usr.awvalid = 1'b1; usr.awaddr = 32'h300; usr.awlen = 8'd1;
    #1;
    vectors++; if (usr.wready !== 1'b0) begin errors++; $display("FAIL wg_before_accept: got %0b want 0", usr.wready); end
    @(negedge ACLK);
    usr.awvalid = 1'b0;
    #1;
    vectors++; if (usr.wready !== 1'b1 || axi.wvalid !== 1'b1 || axi.wdata !== 32'h11 || axi.wstrb !== 4'h3) begin errors++; $display("FAIL wg_flow: got rdy=%0b v=%0b d=%0h s=%0h want 1/1/11/3", usr.wready, axi.wvalid, axi.wdata, axi.wstrb); end
    @(negedge ACLK);
    usr.wdata = 32'h22; usr.wlast = 1'b1;
    #1;
    vectors++; if (axi.wvalid !== 1'b1 || axi.wlast !== 1'b1 || axi.wdata !== 32'h22) begin errors++; $display("FAIL wg_last: got v=%0b l=%0b d=%0h want 1/1/22", axi.wvalid, axi.wlast, axi.wdata); end
    @(negedge ACLK);
    #1;
    vectors++; if (dut.wcredit !== 3'd0 || usr.wready !== 1'b0 || axi.wvalid !== 1'b0) begin errors++; $display("FAIL wg_closed: got cr=%0d rdy=%0b v=%0b want 0/0/0", dut.wcredit, usr.wready, axi.wvalid); end
    usr.wvalid = 1'b0; usr.wlast = 1'b0;
  endtask

  task automatic test_aw_stall();
    do_reset();
    axi.awready = 1'b0;
    usr.awvalid = 1'b1; usr.awaddr = 32'h400; usr.awlen = 8'd5;
    @(negedge ACLK);
    usr.awvalid = 1'b0; usr.awaddr = 32'hDEAD; usr.awlen = 8'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (axi.awvalid !== 1'b1 || axi.awaddr !== 32'h400 || axi.awlen !== 8'd5 || usr.awready !== 1'b0) begin errors++; $display("FAIL stall%0d: got v=%0b a=%0h l=%0d rdy=%0b want 1/400/5/0", i, axi.awvalid, axi.awaddr, axi.awlen, usr.awready); end
      @(negedge ACLK);
    end
    axi.awready = 1'b1;
    @(negedge ACLK);
    #1;
    vectors++; if (axi.awvalid !== 1'b0) begin errors++; $display("FAIL stall_release: got %0b want 0", axi.awvalid); end
  endtask

  task automatic test_read_error();
    int  k;
    logic err_seen;
    do_reset();
    axi.arready = 1'b1;
    usr.arvalid = 1'b1; usr.araddr = 32'h500; usr.arlen = 8'd7;
    @(negedge ACLK);
    usr.arvalid = 1'b0;
    #1;
    vectors++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h500 || axi.arlen !== 8'd7 || dut.rd_cnt !== 3'd1) begin errors++; $display("FAIL rd_ar: got v=%0b a=%0h l=%0d cnt=%0d want 1/500/7/1", axi.arvalid, axi.araddr, axi.arlen, dut.rd_cnt); end
    @(negedge ACLK);
    k = 0; err_seen = 1'b0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      axi.rvalid = 1'b1; axi.rdata = 32'hD0 + 32'(k);
      axi.rresp = (k == 2) ? 2'b10 : 2'b00; axi.rlast = (k == 7);
      usr.rready = (c % 2 == 0);
      #1;
      vectors++; if (usr.rvalid !== 1'b1 || usr.rdata !== 32'hD0 + 32'(k) || usr.rlast !== (k == 7) || axi.rready !== usr.rready) begin errors++; $display("FAIL rd_beat%0d: got v=%0b d=%0h l=%0b rr=%0b want 1/%0h/%0b/%0b", k, usr.rvalid, usr.rdata, usr.rlast, axi.rready, 32'hD0 + 32'(k), (k == 7), usr.rready); end
      vectors++; if (usr.rd_err !== err_seen || dut.rd_cnt !== 3'd1) begin errors++; $display("FAIL rd_state%0d: got err=%0b cnt=%0d want %0b/1", k, usr.rd_err, dut.rd_cnt, err_seen); end
      @(negedge ACLK);
      if (usr.rready) begin
        if (k == 2) err_seen = 1'b1;
        k++;
      end
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; usr.rready = 1'b0;
    #1;
    vectors++; if (k !== 8) begin errors++; $display("FAIL rd_beats_delivered: got %0d want 8", k); end
    vectors++; if (usr.rd_err !== 1'b1 || dut.rd_cnt !== 3'd0) begin errors++; $display("FAIL rd_end: got err=%0b cnt=%0d want 1/0", usr.rd_err, dut.rd_cnt); end
    @(negedge ACLK);
    vectors++; if (usr.rd_err !== 1'b1) begin errors++; $display("FAIL rd_err_sticky: got %0b want 1", usr.rd_err); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    axi.awready = 1'b0;
    usr.awvalid = 1'b1; usr.awaddr = 32'h600; usr.awlen = 8'd3;
    @(negedge ACLK);
    usr.awvalid = 1'b0;
    axi.bvalid = 1'b1; axi.bresp = 2'b10;
    @(negedge ACLK);
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    usr.awvalid = 1'b1; usr.awaddr = 32'h610;
    #1;
    vectors++; if (usr.wr_err !== 1'b1 || axi.awvalid !== 1'b1 || dut.wcredit !== 3'd1) begin errors++; $display("FAIL mid_pre: got err=%0b v=%0b cr=%0d want 1/1/1", usr.wr_err, axi.awvalid, dut.wcredit); end
    ARESET = 1'b1;
    #1;
    vectors++; if (axi.awvalid !== 1'b0 || axi.awaddr !== 32'h0 || axi.awlen !== 8'd0) begin errors++; $display("FAIL mid_aw: got v=%0b a=%0h l=%0d want 0/0/0", axi.awvalid, axi.awaddr, axi.awlen); end
    vectors++; if (dut.wr_cnt !== 3'd0 || dut.wcredit !== 3'd0 || usr.wr_err !== 1'b0 || usr.rd_err !== 1'b0) begin errors++; $display("FAIL mid_state: got cnt=%0d cr=%0d werr=%0b rerr=%0b want 0/0/0/0", dut.wr_cnt, dut.wcredit, usr.wr_err, usr.rd_err); end
    usr.awvalid = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    drive_idle();
    test_reset();
    test_single_write();
    test_outstanding_cap();
    test_w_gating();
    test_aw_stall();
    test_read_error();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
